ber_monitor: RTL and testbench



---
 rtl/ber_pkg.sv | 20 ++
 rtl/ber_ref_delay.sv | 42 ++++
 rtl/ber_monitor.sv | 84 ++++++++
 tb/tb_ber_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// ber_pkg: shared widths plus popcount and saturating-add helpers for the BER monitor
package ber_pkg;
    localparam int MAX_W  = 32;
    localparam int PC_W   = 6;
    localparam int FILL_W = 4;

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                                 input logic [MAX_W-1:0] max);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[MAX_W-1:0];
    endfunction
endpackage

// File: rtl/ber_ref_delay.sv
// ber_ref_delay: sample-enabled reference delay line with fill tracking
module ber_ref_delay import ber_pkg::*; #(
    parameter int WIDTH = 24,
    parameter int DELAY = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] ref_word,
    output logic             ref_valid
);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DELAY);

    logic [FILL_W-1:0] fill;

    // count samples until the delay line holds DELAY valid entries
    always_ff @(posedge clock or posedge reset)
        if (reset) fill <= '0;
        else if (clear) fill <= '0;
        else if (sample && fill != FILL_MAX) fill <= fill + 1'b1;

    assign ref_valid = sample && fill == FILL_MAX;

    if (DELAY == 0) begin : g_bypass
        assign ref_word = din;
    end else begin : g_line
        logic [WIDTH-1:0] line [DELAY];

        // shift a new reference word in on every accepted sample
        always_ff @(posedge clock or posedge reset)
            if (reset) for (int i = 0; i < DELAY; i++) line[i] <= '0;
            else if (clear) for (int i = 0; i < DELAY; i++) line[i] <= '0;
            else if (sample) begin
                line[0] <= din;
                for (int i = 1; i < DELAY; i++) line[i] <= line[i-1];
            end

        assign ref_word = line[DELAY-1];
    end
endmodule

// File: rtl/ber_monitor.sv
// ber_monitor: edge-sampled bit-error-rate monitor with saturating and windowed counters
module ber_monitor import ber_pkg::*; #(
    parameter int WIDTH  = 24,
    parameter int CNT_W  = 16,
    parameter int DELAY  = 0,
    parameter int WINDOW = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             change,
    input  logic [WIDTH-1:0] pattern1,
    input  logic [WIDTH-1:0] pattern2,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] words,
    output logic             error_flag,
    output logic             word_error,
    output logic [CNT_W-1:0] window_errors,
    output logic             window_valid
);
    localparam logic [CNT_W-1:0] MAX_CNT  = '1;
    localparam logic [31:0]      WIN_LAST = (WINDOW > 0) ? 32'(WINDOW - 1) : '0;

    logic             change_d, sample, ref_valid, cmp_valid, win_close;
    logic [WIDTH-1:0] ref_word, diff;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] errors_next, words_next, win_acc, win_acc_next;
    logic [31:0]      win_cnt;

    assign sample = enable & change & ~change_d;

    ber_ref_delay #(.WIDTH(WIDTH), .DELAY(DELAY)) u_delay (
        .clock(clock), .reset(reset), .clear(clear), .sample(sample),
        .din(pattern1), .ref_word(ref_word), .ref_valid(ref_valid)
    );

    // previous strobe level for rising-edge detection, independent of enable
    always_ff @(posedge clock or posedge reset)
        if (reset) change_d <= 1'b0;
        else change_d <= change;

    // stage 1: capture the bit difference of an aligned compare
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cmp_valid <= 1'b0;
            diff      <= '0;
        end else if (clear) begin
            cmp_valid <= 1'b0;
            diff      <= '0;
        end else begin
            cmp_valid <= ref_valid;
            if (ref_valid) diff <= ref_word ^ pattern2;
        end

    assign pc           = popcount(MAX_W'(diff));
    assign errors_next  = CNT_W'(sat_add(MAX_W'(errors), MAX_W'(pc), MAX_W'(MAX_CNT)));
    assign words_next   = CNT_W'(sat_add(MAX_W'(words), 32'd1, MAX_W'(MAX_CNT)));
    assign win_acc_next = CNT_W'(sat_add(MAX_W'(win_acc), MAX_W'(pc), MAX_W'(MAX_CNT)));
    assign win_close    = (WINDOW > 0) && cmp_valid && win_cnt == WIN_LAST;

    // stage 2: accumulate totals and close measurement windows
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            errors <= '0; words <= '0; error_flag <= 1'b0; word_error <= 1'b0;
            window_errors <= '0; window_valid <= 1'b0; win_acc <= '0; win_cnt <= '0;
        end else if (clear) begin
            errors <= '0; words <= '0; error_flag <= 1'b0; word_error <= 1'b0;
            window_errors <= '0; window_valid <= 1'b0; win_acc <= '0; win_cnt <= '0;
        end else begin
            window_valid <= win_close;
            if (cmp_valid) begin
                errors     <= errors_next;
                words      <= words_next;
                word_error <= pc != '0;
                error_flag <= error_flag | (errors_next == MAX_CNT);
                if (WINDOW > 0) begin
                    win_acc <= win_close ? '0 : win_acc_next;
                    win_cnt <= win_close ? '0 : win_cnt + 32'd1;
                    if (win_close) window_errors <= win_acc_next;
                end
            end
        end
endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: table, directed and random checks of three ber_monitor configurations
module tb_ber_monitor;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0, clear = 1'b0, change = 1'b0;
    logic [23:0] pattern1 = '0, pattern2 = '0;

    logic [15:0] errors_0, words_0, werr_0;
    logic [15:0] errors_1, words_1, werr_1;
    logic [7:0]  errors_2, words_2, werr_2;
    logic flag_0, we_0, wv_0, flag_1, we_1, wv_1, flag_2, we_2, wv_2;

    int nchk = 0, nerr = 0;

    always #5 clock = ~clock;

    ber_monitor #(.WIDTH(24), .CNT_W(16), .DELAY(0), .WINDOW(4)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .change(change),
        .pattern1(pattern1), .pattern2(pattern2), .errors(errors_0), .words(words_0),
        .error_flag(flag_0), .word_error(we_0), .window_errors(werr_0), .window_valid(wv_0));
    ber_monitor #(.WIDTH(24), .CNT_W(16), .DELAY(2), .WINDOW(0)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .change(change),
        .pattern1(pattern1), .pattern2(pattern2), .errors(errors_1), .words(words_1),
        .error_flag(flag_1), .word_error(we_1), .window_errors(werr_1), .window_valid(wv_1));
    ber_monitor #(.WIDTH(24), .CNT_W(8), .DELAY(0), .WINDOW(3)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .change(change),
        .pattern1(pattern1), .pattern2(pattern2), .errors(errors_2), .words(words_2),
        .error_flag(flag_2), .word_error(we_2), .window_errors(werr_2), .window_valid(wv_2));

    // reference model: per-instance totals, delay modelled as a FIFO of past references
    int D [3]  = '{0, 2, 0};
    int W [3]  = '{4, 0, 3};
    int MX [3] = '{65535, 65535, 255};
    int m_err [3], m_words [3], m_wacc [3], m_wcnt [3], m_werr [3];
    bit m_flag [3], m_we [3], m_wv [3];
    logic [23:0] hist [$];

    function automatic int smin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 3; i++) begin
            m_err[i] = 0; m_words[i] = 0; m_wacc[i] = 0; m_wcnt[i] = 0; m_werr[i] = 0;
            m_flag[i] = 0; m_we[i] = 0; m_wv[i] = 0;
        end
        hist.delete();
    endfunction

    function automatic void m_sample(input logic [23:0] a, input logic [23:0] b);
        for (int i = 0; i < 3; i++) begin
            logic [23:0] r;
            bit has;
            int pc;
            r = a;
            has = 1;
            if (D[i] > 0) begin
                hist.push_back(a);
                if (hist.size() > D[i]) r = hist.pop_front();
                else has = 0;
            end
            if (has) begin
                pc = $countones(r ^ b);
                m_err[i] = smin(m_err[i] + pc, MX[i]);
                m_words[i] = smin(m_words[i] + 1, MX[i]);
                m_we[i] = pc != 0;
                if (m_err[i] == MX[i]) m_flag[i] = 1;
                if (W[i] > 0) begin
                    m_wacc[i] = smin(m_wacc[i] + pc, MX[i]);
                    m_wcnt[i]++;
                    if (m_wcnt[i] == W[i]) begin
                        m_werr[i] = m_wacc[i];
                        m_wv[i] = 1;
                        m_wacc[i] = 0;
                        m_wcnt[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rd(input int i, output int er, output int wd, output int fl, output int we,
                      output int wv, output int werr);
        case (i)
            0: begin er = int'(errors_0); wd = int'(words_0); fl = int'(flag_0); we = int'(we_0); wv = int'(wv_0); werr = int'(werr_0); end
            1: begin er = int'(errors_1); wd = int'(words_1); fl = int'(flag_1); we = int'(we_1); wv = int'(wv_1); werr = int'(werr_1); end
            default: begin er = int'(errors_2); wd = int'(words_2); fl = int'(flag_2); we = int'(we_2); wv = int'(wv_2); werr = int'(werr_2); end
        endcase
    endtask

    task automatic check_all(input bit with_wv);
        int er, wd, fl, we, wv, werr;
        for (int i = 0; i < 3; i++) begin
            rd(i, er, wd, fl, we, wv, werr);
            chk($sformatf("u%0d.errors", i), er, m_err[i]);
            chk($sformatf("u%0d.words", i), wd, m_words[i]);
            chk($sformatf("u%0d.error_flag", i), fl, int'(m_flag[i]));
            chk($sformatf("u%0d.word_error", i), we, int'(m_we[i]));
            chk($sformatf("u%0d.window_errors", i), werr, m_werr[i]);
            if (with_wv) chk($sformatf("u%0d.window_valid", i), wv, int'(m_wv[i]));
        end
    endtask

    // one change pulse held for 'hold' cycles; outputs checked just after E1 (or later if held)
    task automatic pulse(input logic [23:0] a, input logic [23:0] b, input bit en, input bit clr, input int hold);
        for (int i = 0; i < 3; i++) m_wv[i] = 0;
        pattern1 = a; pattern2 = b; enable = en; clear = clr; change = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        if (clr) m_clear();
        else if (en) m_sample(a, b);
        for (int k = 1; k < hold; k++) @(posedge clock);
        #1 change = 1'b0;
        @(posedge clock); #1;
        check_all(hold == 1);
    endtask

    typedef struct {
        logic [23:0] p1, p2;
        bit en;
        int hold;
        int e_err, e_words;
        bit e_we, e_wv;
        int e_werr;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{24'hE38E38, 24'hE38E38, 1, 1,  0, 1, 0, 0,  0};
        tbl[1] = '{24'hFFFFFF, 24'h000000, 1, 4, 24, 2, 1, 0,  0};
        tbl[2] = '{24'h000001, 24'h000000, 1, 1, 25, 3, 1, 0,  0};
        tbl[3] = '{24'h0000FF, 24'h000000, 0, 1, 25, 3, 1, 0,  0};
        tbl[4] = '{24'h000003, 24'h000000, 1, 1, 27, 4, 1, 1, 27};
        tbl[5] = '{24'h00001F, 24'h000000, 1, 1, 32, 5, 1, 0, 27};
        m_clear();
        #12 reset = 1'b0;
        #1 check_all(1);

        // table-driven vectors against u0 (DELAY=0, WINDOW=4), model checks all instances
        for (int v = 0; v < 6; v++) begin
            pulse(tbl[v].p1, tbl[v].p2, tbl[v].en, 1'b0, tbl[v].hold);
            chk($sformatf("tbl%0d.errors", v), int'(errors_0), tbl[v].e_err);
            chk($sformatf("tbl%0d.words", v), int'(words_0), tbl[v].e_words);
            chk($sformatf("tbl%0d.word_error", v), int'(we_0), int'(tbl[v].e_we));
            chk($sformatf("tbl%0d.window_errors", v), int'(werr_0), tbl[v].e_werr);
            if (tbl[v].hold == 1) chk($sformatf("tbl%0d.window_valid", v), int'(wv_0), int'(tbl[v].e_wv));
        end

        // windows of 1,2,3,4 errors then 5
        pulse(24'h0, 24'h0, 1, 1, 1);
        pulse(24'h0, 24'h1, 1, 0, 1);
        pulse(24'h0, 24'h3, 1, 0, 1);
        pulse(24'h0, 24'h7, 1, 0, 1);
        chk("win.no_early_pulse", int'(wv_0), 0);
        pulse(24'h0, 24'hF, 1, 0, 1);
        chk("win.pulse", int'(wv_0), 1);
        chk("win.sum10", int'(werr_0), 10);
        pulse(24'h0, 24'h1F, 1, 0, 1);
        chk("win.no_pulse", int'(wv_0), 0);
        chk("win.hold10", int'(werr_0), 10);
        for (int k = 0; k < 3; k++) pulse(24'h5, 24'h5, 1, 0, 1);
        chk("win.next_pulse", int'(wv_0), 1);
        chk("win.next_sum5", int'(werr_0), 5);

        // reference alignment with DELAY=2 on u1
        pulse(24'h0, 24'h0, 1, 1, 1);
        pulse(24'd1, 24'd9, 1, 0, 1);
        pulse(24'd2, 24'd9, 1, 0, 1);
        chk("dly.fill_words", int'(words_1), 0);
        pulse(24'd3, 24'd1, 1, 0, 1);
        pulse(24'd4, 24'd2, 1, 0, 1);
        chk("dly.words", int'(words_1), 2);
        chk("dly.errors", int'(errors_1), 0);
        pulse(24'h0, 24'h0, 1, 1, 1);
        pulse(24'd1, 24'd9, 1, 0, 1);
        pulse(24'd2, 24'd9, 1, 0, 1);
        pulse(24'd3, 24'd1, 1, 0, 1);
        pulse(24'd4, 24'd3, 1, 0, 1);
        chk("dly.errors_mis", int'(errors_1), $countones(24'd2 ^ 24'd3));

        // saturation on the 8-bit counters of u2
        pulse(24'h0, 24'h0, 1, 1, 1);
        for (int k = 0; k < 11; k++) pulse(24'hFFFFFF, 24'h000000, 1, 0, 1);
        chk("sat.errors", int'(errors_2), 255);
        chk("sat.flag", int'(flag_2), 1);
        chk("sat.wide_errors", int'(errors_0), 264);
        pulse(24'h0, 24'h0, 1, 1, 1);
        chk("clr.errors", int'(errors_2), 0);
        chk("clr.flag", int'(flag_2), 0);
        pulse(24'hFFFFFF, 24'h0, 0, 0, 1);
        chk("dis.words", int'(words_2), 0);

        // reset between E0 and E1 of a mismatching sample
        pulse(24'h0, 24'h0, 1, 0, 1);
        pulse(24'h0, 24'h0, 1, 0, 1);
        pattern1 = 24'hFFFFFF; pattern2 = 24'h0; enable = 1'b1; change = 1'b1;
        @(posedge clock); #2 reset = 1'b1;
        #2 reset = 1'b0;
        m_clear();
        change = 1'b0;
        @(posedge clock); #1;
        check_all(1);
        chk("rst.errors", int'(errors_0), 0);
        chk("rst.words", int'(words_0), 0);
        pulse(24'd7, 24'd0, 1, 0, 1);
        pulse(24'd8, 24'd0, 1, 0, 1);
        chk("rst.refill", int'(words_1), 0);
        pulse(24'd9, 24'd0, 1, 0, 1);
        chk("rst.refilled", int'(words_1), 1);

        // randomized pulses against the model
        for (int n = 0; n < 300; n++) begin
            logic [23:0] a, b;
            int mode;
            a = 24'($urandom);
            mode = $urandom_range(0, 3);
            b = mode == 0 ? a :
                mode == 1 ? a ^ (24'd1 << $urandom_range(0, 23)) :
                mode == 2 ? 24'($urandom) :
                a ^ 24'($urandom & $urandom & $urandom);
            pulse(a, b, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
